// File: rtl/ysyx_23060191_mem_arbiter_if.sv
// Handshaked memory bus between a requester (master) and a memory port (slave).
// Request and response channels each use their own valid/ready pair.
interface ysyx_23060191_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     addr;
   logic                  wen;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wmask;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, addr, wen, wdata, wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, addr, wen, wdata, wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/ysyx_23060191_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU (m0) and the LSU (m1).
// At most one transaction is in flight; request and response paths are combinational pass-through.
module ysyx_23060191_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                        clk,
   input  logic                        rstn,
   ysyx_23060191_mem_arbiter_if.slave  m0,
   ysyx_23060191_mem_arbiter_if.slave  m1,
   ysyx_23060191_mem_arbiter_if.master s,
   output logic                        grant,
   output logic                        busy
);
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                grant_nxt;
   logic                last_grant;
   logic                last_grant_nxt;

   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_wen;
   logic [DATA_W-1:0]   sel_wdata;
   logic [MASK_W-1:0]   sel_wmask;
   logic                sel_rsp_ready;

   // Payload is taken straight from the granted master; masters hold it stable until accepted.
   assign sel_addr      = grant ? m1.addr      : m0.addr;
   assign sel_wen       = grant ? m1.wen       : m0.wen;
   assign sel_wdata     = grant ? m1.wdata     : m0.wdata;
   assign sel_wmask     = grant ? m1.wmask     : m0.wmask;
   assign sel_rsp_ready = grant ? m1.rsp_ready : m0.rsp_ready;

   assign busy = (state != IDLE);

   // last_grant resets to 1 so the IFU wins the first tie.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      unique case (state)
         IDLE: begin
            if (m0.req_valid || m1.req_valid) begin
               state_nxt = REQ;
               if (m0.req_valid && m1.req_valid) begin
                  grant_nxt = ~last_grant;
               end else begin
                  grant_nxt = m1.req_valid;
               end
            end
         end
         REQ: begin
            if (s.req_ready) begin
               state_nxt = RSP;
            end
         end
         RSP: begin
            if (s.rsp_valid && sel_rsp_ready) begin
               state_nxt      = IDLE;
               last_grant_nxt = grant;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s.req_valid  = 1'b0;
      s.addr       = '0;
      s.wen        = 1'b0;
      s.wdata      = '0;
      s.wmask      = '0;
      s.rsp_ready  = 1'b0;
      m0.req_ready = 1'b0;
      m0.rsp_valid = 1'b0;
      m0.rsp_rdata = '0;
      m0.rsp_err   = 1'b0;
      m1.req_ready = 1'b0;
      m1.rsp_valid = 1'b0;
      m1.rsp_rdata = '0;
      m1.rsp_err   = 1'b0;
      unique case (state)
         REQ: begin
            s.req_valid = 1'b1;
            s.addr      = sel_addr;
            s.wen       = sel_wen;
            s.wdata     = sel_wdata;
            s.wmask     = sel_wmask;
            if (grant) begin
               m1.req_ready = s.req_ready;
            end else begin
               m0.req_ready = s.req_ready;
            end
         end
         RSP: begin
            s.rsp_ready = sel_rsp_ready;
            if (grant) begin
               m1.rsp_valid = s.rsp_valid;
               m1.rsp_rdata = s.rsp_rdata;
               m1.rsp_err   = s.rsp_err;
            end else begin
               m0.rsp_valid = s.rsp_valid;
               m0.rsp_rdata = s.rsp_rdata;
               m0.rsp_err   = s.rsp_err;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Bench for the two-master memory arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of ownership and round-robin fairness.
module tb_ysyx_23060191_mem_arbiter;
   logic clk;
   logic rstn;
   logic grant;
   logic busy;

   int n_checks;
   int n_fail;

   ysyx_23060191_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   ysyx_23060191_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
   ysyx_23060191_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

   ysyx_23060191_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .grant (grant),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-master drive values used by the randomized run.
   logic        rv [2];
   logic [31:0] ra [2];
   logic        rw [2];
   logic [31:0] rd [2];
   logic [3:0]  rm [2];
   logic        rr [2];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_if.req_valid = 1'b0; m0_if.addr = '0; m0_if.wen = 1'b0;
      m0_if.wdata = '0; m0_if.wmask = '0; m0_if.rsp_ready = 1'b0;
      m1_if.req_valid = 1'b0; m1_if.addr = '0; m1_if.wen = 1'b0;
      m1_if.wdata = '0; m1_if.wmask = '0; m1_if.rsp_ready = 1'b0;
      s_if.req_ready = 1'b0; s_if.rsp_valid = 1'b0;
      s_if.rsp_rdata = '0; s_if.rsp_err = 1'b0;
   endtask

   task automatic apply_drives();
      m0_if.req_valid = rv[0]; m0_if.addr = ra[0]; m0_if.wen = rw[0];
      m0_if.wdata = rd[0]; m0_if.wmask = rm[0]; m0_if.rsp_ready = rr[0];
      m1_if.req_valid = rv[1]; m1_if.addr = ra[1]; m1_if.wen = rw[1];
      m1_if.wdata = rd[1]; m1_if.wmask = rm[1]; m1_if.rsp_ready = rr[1];
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 1'b0;
      next_cycle();
      next_cycle();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      logic [84:0] ctl;
      idle_inputs();
      m0_if.req_valid = 1'b1; m0_if.addr = 32'h8000_0040;
      m1_if.req_valid = 1'b1; m1_if.addr = 32'h8000_0080;
      rstn = 1'b0;
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         @(negedge clk);
         ctl = {busy, grant, s_if.req_valid, s_if.rsp_ready, m0_if.req_ready, m0_if.rsp_valid,
                m1_if.req_ready, m1_if.rsp_valid, s_if.addr, s_if.wen, s_if.wdata, s_if.wmask};
         n_checks++;
         if (ctl !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %h expected 0", k, ctl);
         end
      end
      rstn = 1'b1;
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (s_if.req_valid !== 1'b1 || grant !== 1'b0 || s_if.addr !== 32'h8000_0040 || m1_if.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_grant: got valid=%b grant=%b addr=%h expected valid=1 grant=0 addr=80000040",
                  s_if.req_valid, grant, s_if.addr);
      end
      do_reset();
   endtask

   task automatic test_ifu_read();
      idle_inputs();
      m0_if.req_valid = 1'b1; m0_if.addr = 32'h8000_0000; m0_if.rsp_ready = 1'b1;
      s_if.req_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || s_if.req_valid !== 1'b0 || m0_if.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ifu_arb_cycle: got busy=%b s_req_valid=%b ready=%b expected 0/0/0", busy, s_if.req_valid, m0_if.req_ready);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (s_if.req_valid !== 1'b1 || m0_if.req_ready !== 1'b1 || s_if.addr !== 32'h8000_0000 || s_if.wen !== 1'b0 ||
          grant !== 1'b0 || {m1_if.req_ready, m1_if.rsp_valid, m1_if.rsp_err, m1_if.rsp_rdata} !== '0) begin
         n_fail++;
         $display("FAIL ifu_accept: got valid=%b ready=%b addr=%h wen=%b grant=%b expected 1/1/80000000/0/0",
                  s_if.req_valid, m0_if.req_ready, s_if.addr, s_if.wen, grant);
      end
      next_cycle();
      m0_if.req_valid = 1'b0;
      s_if.req_ready = 1'b0;
      s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'h0010_0073; s_if.rsp_err = 1'b0;
      @(negedge clk);
      n_checks++;
      if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_rdata !== 32'h0010_0073 || m0_if.rsp_err !== 1'b0 ||
          s_if.rsp_ready !== 1'b1 || m0_if.req_ready !== 1'b0 ||
          {m1_if.req_ready, m1_if.rsp_valid, m1_if.rsp_err, m1_if.rsp_rdata} !== '0) begin
         n_fail++;
         $display("FAIL ifu_response: got rsp_valid=%b rdata=%h s_rsp_ready=%b m1_rsp_valid=%b expected 1/00100073/1/0",
                  m0_if.rsp_valid, m0_if.rsp_rdata, s_if.rsp_ready, m1_if.rsp_valid);
      end
      next_cycle();
      s_if.rsp_valid = 1'b0; s_if.rsp_rdata = '0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || m0_if.rsp_valid !== 1'b0 || s_if.rsp_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ifu_back_idle: got busy=%b rsp_valid=%b expected 0/0", busy, m0_if.rsp_valid);
      end
      next_cycle();
   endtask

   task automatic test_lsu_write();
      logic exp_rdy;
      idle_inputs();
      m1_if.req_valid = 1'b1; m1_if.addr = 32'h8000_1000; m1_if.wen = 1'b1;
      m1_if.wdata = 32'hDEAD_BEEF; m1_if.wmask = 4'hF; m1_if.rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || s_if.req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lsu_arb_cycle: got busy=%b s_req_valid=%b expected 0/0", busy, s_if.req_valid);
      end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         s_if.req_ready = (k == 4);
         exp_rdy = (k == 4);
         @(negedge clk);
         n_checks++;
         if (s_if.req_valid !== 1'b1 || s_if.addr !== 32'h8000_1000 || s_if.wen !== 1'b1 ||
             s_if.wdata !== 32'hDEAD_BEEF || s_if.wmask !== 4'hF || busy !== 1'b1 || grant !== 1'b1 ||
             m1_if.req_ready !== exp_rdy || m0_if.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lsu_req_hold cycle %0d: got valid=%b addr=%h wdata=%h mask=%h busy=%b grant=%b ready=%b expected ready=%b",
                     k, s_if.req_valid, s_if.addr, s_if.wdata, s_if.wmask, busy, grant, m1_if.req_ready, exp_rdy);
         end
      end
      next_cycle();
      m1_if.req_valid = 1'b0;
      s_if.req_ready = 1'b0;
      s_if.rsp_valid = 1'b1; s_if.rsp_rdata = '0; s_if.rsp_err = 1'b0;
      @(negedge clk);
      n_checks++;
      if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h0 || busy !== 1'b1 || m0_if.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lsu_response: got rsp_valid=%b rdata=%h busy=%b m0_rsp_valid=%b expected 1/0/1/0",
                  m1_if.rsp_valid, m1_if.rsp_rdata, busy, m0_if.rsp_valid);
      end
      next_cycle();
      s_if.rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL lsu_back_idle: got busy=%b expected 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      int ngr;
      int nrsp;
      int owner;
      int prev_cyc;
      logic exp_g;
      logic [31:0] got_rd;
      logic got_v;
      logic other_v;
      idle_inputs();
      m0_if.req_valid = 1'b1; m0_if.addr = 32'h8000_0100; m0_if.rsp_ready = 1'b1;
      m1_if.req_valid = 1'b1; m1_if.addr = 32'h8000_0200; m1_if.rsp_ready = 1'b1;
      s_if.req_ready = 1'b1; s_if.rsp_valid = 1'b1;
      ngr = 0; nrsp = 0; owner = 0; prev_cyc = 0;
      for (int cyc = 0; cyc < 60 && nrsp < 6; cyc++) begin
         if (ngr >= 6) begin
            m0_if.req_valid = 1'b0;
            m1_if.req_valid = 1'b0;
         end
         s_if.rsp_rdata = $urandom;
         @(negedge clk);
         if (s_if.req_valid === 1'b1) begin
            exp_g = ngr[0];
            n_checks++;
            if (grant !== exp_g || s_if.addr !== (exp_g ? 32'h8000_0200 : 32'h8000_0100) || (ngr > 0 && cyc - prev_cyc != 3)) begin
               n_fail++;
               $display("FAIL b2b_grant %0d: got grant=%b addr=%h gap=%0d expected grant=%b gap=3",
                        ngr, grant, s_if.addr, cyc - prev_cyc, exp_g);
            end
            owner = ngr % 2;
            prev_cyc = cyc;
            ngr++;
         end
         if (s_if.rsp_ready === 1'b1) begin
            got_v   = (owner == 1) ? m1_if.rsp_valid : m0_if.rsp_valid;
            got_rd  = (owner == 1) ? m1_if.rsp_rdata : m0_if.rsp_rdata;
            other_v = (owner == 1) ? m0_if.rsp_valid : m1_if.rsp_valid;
            n_checks++;
            if (got_v !== 1'b1 || got_rd !== s_if.rsp_rdata || other_v !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_response %0d: got valid=%b rdata=%h other_valid=%b expected 1/%h/0",
                        nrsp, got_v, got_rd, other_v, s_if.rsp_rdata);
            end
            nrsp++;
         end
         next_cycle();
      end
      n_checks++;
      if (nrsp < 6) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d responses expected 6", nrsp);
      end
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: got busy=%b expected 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_backpressure();
      idle_inputs();
      m1_if.req_valid = 1'b1; m1_if.addr = 32'h8000_0300;
      s_if.req_ready = 1'b1;
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (m1_if.req_ready !== 1'b1 || grant !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_accept: got ready=%b grant=%b expected 1/1", m1_if.req_ready, grant);
      end
      next_cycle();
      m1_if.req_valid = 1'b0;
      s_if.req_ready = 1'b0;
      s_if.rsp_valid = 1'b1; s_if.rsp_err = 1'b1; s_if.rsp_rdata = 32'h1234_5678;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (s_if.rsp_ready !== 1'b0 || m1_if.rsp_valid !== 1'b1 || m1_if.rsp_err !== 1'b1 ||
             busy !== 1'b1 || s_if.req_valid !== 1'b0 || m0_if.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall cycle %0d: got s_rsp_ready=%b rsp_valid=%b err=%b busy=%b expected 0/1/1/1",
                     k, s_if.rsp_ready, m1_if.rsp_valid, m1_if.rsp_err, busy);
         end
         next_cycle();
      end
      m1_if.rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_if.rsp_ready !== 1'b1 || m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL bp_release: got s_rsp_ready=%b rsp_valid=%b rdata=%h expected 1/1/12345678",
                  s_if.rsp_ready, m1_if.rsp_valid, m1_if.rsp_rdata);
      end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle: got busy=%b expected 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_reset_in_rsp();
      // Complete an IFU transaction first so the arbiter's history favours the LSU.
      idle_inputs();
      m0_if.req_valid = 1'b1; m0_if.addr = 32'h8000_0400; m0_if.rsp_ready = 1'b1;
      s_if.req_ready = 1'b1; s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'hCAFE_0001;
      next_cycle();
      next_cycle();
      m0_if.req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_rdata !== 32'hCAFE_0001) begin
         n_fail++;
         $display("FAIL rr_setup_response: got valid=%b rdata=%h expected 1/cafe0001", m0_if.rsp_valid, m0_if.rsp_rdata);
      end
      next_cycle();
      idle_inputs();
      m0_if.req_valid = 1'b1; m0_if.addr = 32'h8000_0500;
      s_if.req_ready = 1'b1;
      next_cycle();
      next_cycle();
      m0_if.req_valid = 1'b0;
      s_if.req_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || s_if.req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_in_rsp: got busy=%b s_req_valid=%b expected 1/0", busy, s_if.req_valid);
      end
      next_cycle();
      rstn = 1'b0;
      next_cycle();
      rstn = 1'b1;
      m0_if.req_valid = 1'b1; m0_if.addr = 32'h8000_0600; m0_if.rsp_ready = 1'b1;
      m1_if.req_valid = 1'b1; m1_if.addr = 32'h8000_0700; m1_if.rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || grant !== 1'b0 || s_if.req_valid !== 1'b0 || s_if.rsp_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_after_reset: got busy=%b grant=%b s_req_valid=%b expected 0/0/0", busy, grant, s_if.req_valid);
      end
      next_cycle();
      s_if.req_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (grant !== 1'b0 || s_if.req_valid !== 1'b1 || s_if.addr !== 32'h8000_0600 || m0_if.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rr_tie_after_reset: got grant=%b addr=%h ready=%b expected 0/80000600/1", grant, s_if.addr, m0_if.req_ready);
      end
      next_cycle();
      m0_if.req_valid = 1'b0;
      m1_if.req_valid = 1'b0;
      s_if.req_ready = 1'b0;
      s_if.rsp_valid = 1'b1; s_if.rsp_rdata = 32'hCAFE_0002;
      @(negedge clk);
      n_checks++;
      if (m0_if.rsp_valid !== 1'b1 || m0_if.rsp_rdata !== 32'hCAFE_0002 || m1_if.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_served: got valid=%b rdata=%h m1_valid=%b expected 1/cafe0002/0", m0_if.rsp_valid, m0_if.rsp_rdata, m1_if.rsp_valid);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_random();
      logic [31:0] mem [16];
      int owner;
      bit accepted;
      bit last_w;
      bit grant_e;
      bit req_act [2];
      bit wait_rsp [2];
      bit rsp_pend;
      bit rsp_shown;
      logic [31:0] rsp_data;
      bit rsp_e;
      int idx;
      int nprint;
      logic e_sqv, e_swen, e_srr;
      logic [31:0] e_saddr, e_swdata;
      logic [3:0] e_swmask;
      logic e_rr [2];
      logic e_rv [2];
      logic e_er [2];
      logic [31:0] e_rd [2];
      logic [142:0] exp_v;
      logic [142:0] got_v;
      do_reset();
      owner = -1; accepted = 1'b0; last_w = 1'b1; grant_e = 1'b0;
      rsp_pend = 1'b0; rsp_shown = 1'b0; rsp_data = '0; rsp_e = 1'b0; nprint = 0;
      for (int i = 0; i < 2; i++) begin
         req_act[i] = 1'b0; wait_rsp[i] = 1'b0;
         rv[i] = 1'b0; ra[i] = '0; rw[i] = 1'b0; rd[i] = '0; rm[i] = '0; rr[i] = 1'b0;
      end
      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req_act[i] && !wait_rsp[i] && $urandom_range(0, 2) == 0) begin
               req_act[i] = 1'b1;
               ra[i] = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
               rw[i] = 1'($urandom_range(0, 1));
               rd[i] = $urandom;
               rm[i] = 4'($urandom_range(0, 15));
            end
            rv[i] = req_act[i];
            rr[i] = ($urandom_range(0, 3) != 0);
         end
         s_if.req_ready = 1'($urandom_range(0, 1));
         if (rsp_pend) begin
            if (!rsp_shown && $urandom_range(0, 1) == 1) rsp_shown = 1'b1;
            s_if.rsp_valid = rsp_shown; s_if.rsp_rdata = rsp_data; s_if.rsp_err = rsp_e;
         end else begin
            // Stray responses while nothing is outstanding must be ignored.
            s_if.rsp_valid = ($urandom_range(0, 3) == 0);
            s_if.rsp_rdata = $urandom; s_if.rsp_err = 1'($urandom_range(0, 1));
         end
         apply_drives();
         @(negedge clk);
         e_sqv = 1'b0; e_swen = 1'b0; e_srr = 1'b0; e_saddr = '0; e_swdata = '0; e_swmask = '0;
         for (int i = 0; i < 2; i++) begin
            e_rr[i] = 1'b0; e_rv[i] = 1'b0; e_er[i] = 1'b0; e_rd[i] = '0;
         end
         if (owner >= 0 && !accepted) begin
            e_sqv = 1'b1; e_saddr = ra[owner]; e_swen = rw[owner]; e_swdata = rd[owner]; e_swmask = rm[owner];
            e_rr[owner] = s_if.req_ready;
         end
         if (owner >= 0 && accepted) begin
            e_srr = rr[owner];
            e_rv[owner] = s_if.rsp_valid; e_rd[owner] = s_if.rsp_rdata; e_er[owner] = s_if.rsp_err;
         end
         exp_v = {(owner >= 0), grant_e, e_sqv, e_saddr, e_swen, e_swdata, e_swmask, e_srr,
                  e_rr[0], e_rv[0], e_er[0], e_rd[0], e_rr[1], e_rv[1], e_er[1], e_rd[1]};
         got_v = {busy, grant, s_if.req_valid, s_if.addr, s_if.wen, s_if.wdata, s_if.wmask, s_if.rsp_ready,
                  m0_if.req_ready, m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata,
                  m1_if.req_ready, m1_if.rsp_valid, m1_if.rsp_err, m1_if.rsp_rdata};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            if (nprint < 8) $display("FAIL random_cycle %0d: got %h expected %h", cyc, got_v, exp_v);
            nprint++;
         end
         if (owner >= 0 && !accepted) begin
            if (s_if.req_ready) begin
               accepted = 1'b1;
               req_act[owner] = 1'b0;
               wait_rsp[owner] = 1'b1;
               idx = int'(ra[owner][5:2]);
               if (rw[owner]) begin
                  for (int b = 0; b < 4; b++) if (rm[owner][b]) mem[idx][8*b +: 8] = rd[owner][8*b +: 8];
                  rsp_data = '0;
               end else begin
                  rsp_data = mem[idx];
               end
               rsp_e = ($urandom_range(0, 3) == 0);
               rsp_pend = 1'b1;
               rsp_shown = 1'b0;
            end
         end else if (owner >= 0) begin
            if (s_if.rsp_valid && rr[owner]) begin
               wait_rsp[owner] = 1'b0;
               last_w = (owner == 1);
               owner = -1;
               accepted = 1'b0;
               rsp_pend = 1'b0;
            end
         end else if (req_act[0] || req_act[1]) begin
            if (req_act[0] && req_act[1]) owner = last_w ? 0 : 1;
            else owner = req_act[1] ? 1 : 0;
            grant_e = (owner == 1);
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rstn = 1'b0;
      idle_inputs();
      test_reset();
      test_ifu_read();
      test_lsu_write();
      test_back_to_back();
      test_backpressure();
      test_reset_in_rsp();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
